// File: rtl/c2h_adapter_pkg.sv
// Shared types and constants for the C2H store-and-forward adapter.
package c2h_adapter_pkg;

  localparam int unsigned RX_LEN_DFLT    = 512;
  localparam int unsigned BYTES_PER_BEAT = RX_LEN_DFLT / 8;

  localparam int unsigned CMPT_LEN_LSB   = 0;
  localparam int unsigned CMPT_SEQ_LSB   = 16;
  localparam int unsigned CMPT_TRUNC_BIT = 32;

  typedef struct packed {
    logic        trunc;
    logic [15:0] len;
  } len_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CMPT = 2'd2
  } egress_state_t;

  function automatic logic [63:0] pack_cmpt(input logic trunc, input logic [15:0] seq,
                                            input logic [15:0] len);
    logic [63:0] r;
    r = 64'd0;
    r[CMPT_LEN_LSB +: 16] = len;
    r[CMPT_SEQ_LSB +: 16] = seq;
    r[CMPT_TRUNC_BIT]     = trunc;
    return r;
  endfunction

endpackage

// File: rtl/c2h_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; DEPTH must be a power of 2.
module c2h_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_s, wr_ok_s, rd_ok_s;

  assign full_s    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  // A write into a full FIFO is allowed when the head leaves in the same cycle.
  assign wr_ok_s   = wr_en_i & (~full_s | rd_en_i);
  assign rd_ok_s   = rd_en_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/c2h_pkt_adapter.sv
// Store-and-forward adapter: generator beats -> QDMA C2H stream plus one completion per packet.
// Optional packet/byte/truncation statistics outputs when C2H_ADAPTER_STATS_EN is defined.
module c2h_pkt_adapter
  import c2h_adapter_pkg::*;
#(
  parameter int unsigned RX_LEN        = 512,
  parameter int unsigned DATA_DEPTH    = 128,
  parameter int unsigned LEN_DEPTH     = 16,
  parameter int unsigned MAX_PKT_BYTES = 4096,
  parameter int unsigned QID_W         = 11
) (
  input  logic                axi_aclk,
  input  logic                axi_areset,
  input  logic                rx_valid,
  input  logic [RX_LEN-1:0]   rx_data,
  input  logic [RX_LEN/8-1:0] rx_ben,
  input  logic                rx_last,
  output logic                rx_ready,
  input  logic [QID_W-1:0]    c2h_qid,
  output logic                m_c2h_tvalid,
  input  logic                m_c2h_tready,
  output logic [RX_LEN-1:0]   m_c2h_tdata,
  output logic                m_c2h_tlast,
  output logic [15:0]         m_c2h_len,
  output logic [5:0]          m_c2h_mty,
  output logic [QID_W-1:0]    m_c2h_qid,
  output logic                cmpt_valid,
  input  logic                cmpt_ready,
  output logic [63:0]         cmpt_data
`ifdef C2H_ADAPTER_STATS_EN
  ,
  output logic [31:0]         stat_pkts,
  output logic [47:0]         stat_bytes,
  output logic [15:0]         stat_trunc
`endif
);

  localparam int unsigned BPB      = RX_LEN / 8;
  localparam int unsigned LOG2_BPB = $clog2(BPB);
  localparam int unsigned BCNT_W   = LOG2_BPB + 1;
  localparam int unsigned DCNT_W   = $clog2(DATA_DEPTH) + 1;
  localparam int unsigned LCNT_W   = $clog2(LEN_DEPTH) + 1;
  localparam logic [DCNT_W-1:0] DATA_LIMIT = DCNT_W'(DATA_DEPTH);
  localparam logic [LCNT_W-1:0] LEN_LIMIT  = LCNT_W'(LEN_DEPTH);
  localparam logic [17:0]       MAX_B      = 18'(MAX_PKT_BYTES);

  // ---------------- ingress ----------------
  logic [DCNT_W-1:0] data_cnt_s;
  logic [LCNT_W-1:0] len_cnt_s;
  logic              data_empty_s, len_empty_s;
  logic [RX_LEN-1:0] data_head_s;
  len_entry_t        len_head_s, len_push_entry_s;
  logic              rx_accept_s, data_wr_s, len_push_s, over_s;
  logic [BCNT_W-1:0] ben_cnt_s;
  logic [17:0]       acc_sum_s;
  logic [16:0]       acc_sat_s;
  logic [16:0]       acc_q;
  logic              in_trunc_q;

  assign rx_ready    = ~axi_areset & (data_cnt_s < DATA_LIMIT) & (len_cnt_s < LEN_LIMIT);
  assign rx_accept_s = rx_valid & rx_ready;

  always_comb begin
    ben_cnt_s = '0;
    for (int i = 0; i < BPB; i++) begin
      ben_cnt_s = ben_cnt_s + BCNT_W'(rx_ben[i]);
    end
  end

  assign acc_sum_s  = {1'b0, acc_q} + 18'(ben_cnt_s);
  assign acc_sat_s  = acc_sum_s[17] ? 17'h1FFFF : acc_sum_s[16:0];
  // Beats starting at or past the limit are swallowed so the stored beat count matches the clamped length.
  assign data_wr_s  = rx_accept_s & ({1'b0, acc_q} < MAX_B);
  assign over_s     = in_trunc_q | (acc_sum_s > MAX_B);
  assign len_push_s = rx_accept_s & rx_last;
  assign len_push_entry_s.trunc = over_s;
  assign len_push_entry_s.len   = over_s ? MAX_B[15:0] : acc_sat_s[15:0];

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      acc_q      <= 17'd0;
      in_trunc_q <= 1'b0;
    end else if (rx_accept_s) begin
      acc_q      <= rx_last ? 17'd0 : acc_sat_s;
      in_trunc_q <= rx_last ? 1'b0 : over_s;
    end
  end

  // ---------------- egress ----------------
  egress_state_t     state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic              trunc_q, trunc_d;
  logic [QID_W-1:0]  qid_q, qid_d;
  logic [15:0]       beats_q, beats_d;
  logic [15:0]       idx_q, idx_d;
  logic [5:0]        mty_q, mty_d;
  logic [15:0]       seq_q, seq_d;
  logic [15:0]       beats_calc_s;
  logic [LOG2_BPB-1:0] mty_calc_s;
  logic              in_send_s, last_beat_s, beat_hs_s, len_pop_s, cmpt_hs_s;

  c2h_sync_fifo #(.WIDTH(RX_LEN), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk_i     (axi_aclk),
    .srst_i    (axi_areset),
    .wr_en_i   (data_wr_s),
    .wr_data_i (rx_data),
    .rd_en_i   (beat_hs_s),
    .rd_data_o (data_head_s),
    .empty_o   (data_empty_s),
    .count_o   (data_cnt_s)
  );

  c2h_sync_fifo #(.WIDTH($bits(len_entry_t)), .DEPTH(LEN_DEPTH)) u_len_fifo (
    .clk_i     (axi_aclk),
    .srst_i    (axi_areset),
    .wr_en_i   (len_push_s),
    .wr_data_i (len_push_entry_s),
    .rd_en_i   (len_pop_s),
    .rd_data_o (len_head_s),
    .empty_o   (len_empty_s),
    .count_o   (len_cnt_s)
  );

  // A zero-length packet still owns one stored beat.
  always_comb begin
    beats_calc_s = (len_head_s.len >> LOG2_BPB) + {15'd0, |len_head_s.len[LOG2_BPB-1:0]};
    if (beats_calc_s == 16'd0) begin
      beats_calc_s = 16'd1;
    end else begin
      beats_calc_s = beats_calc_s;
    end
    mty_calc_s = ~len_head_s.len[LOG2_BPB-1:0] + LOG2_BPB'(1);
  end

  assign in_send_s    = (state_q == SEND);
  assign last_beat_s  = in_send_s & (idx_q == beats_q - 16'd1);
  assign m_c2h_tvalid = in_send_s & ~data_empty_s;
  assign m_c2h_tdata  = m_c2h_tvalid ? data_head_s : '0;
  assign m_c2h_tlast  = last_beat_s;
  assign m_c2h_mty    = last_beat_s ? mty_q : 6'd0;
  assign m_c2h_len    = len_q;
  assign m_c2h_qid    = qid_q;
  assign beat_hs_s    = m_c2h_tvalid & m_c2h_tready;
  assign len_pop_s    = beat_hs_s & last_beat_s;
  assign cmpt_valid   = (state_q == CMPT);
  assign cmpt_data    = cmpt_valid ? pack_cmpt(trunc_q, seq_q, len_q) : 64'd0;
  assign cmpt_hs_s    = cmpt_valid & cmpt_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    trunc_d = trunc_q;
    qid_d   = qid_q;
    beats_d = beats_q;
    idx_d   = idx_q;
    mty_d   = mty_q;
    seq_d   = seq_q;
    case (state_q)
      IDLE: begin
        if (~len_empty_s) begin
          state_d = SEND;
          len_d   = len_head_s.len;
          trunc_d = len_head_s.trunc;
          qid_d   = c2h_qid;
          beats_d = beats_calc_s;
          mty_d   = 6'(mty_calc_s);
          idx_d   = 16'd0;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (beat_hs_s) begin
          if (last_beat_s) begin
            state_d = CMPT;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end else begin
          state_d = SEND;
        end
      end
      CMPT: begin
        if (cmpt_ready) begin
          seq_d   = seq_q + 16'd1;
          state_d = IDLE;
        end else begin
          state_d = CMPT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q <= IDLE;
      len_q   <= 16'd0;
      trunc_q <= 1'b0;
      qid_q   <= '0;
      beats_q <= 16'd0;
      idx_q   <= 16'd0;
      mty_q   <= 6'd0;
      seq_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      trunc_q <= trunc_d;
      qid_q   <= qid_d;
      beats_q <= beats_d;
      idx_q   <= idx_d;
      mty_q   <= mty_d;
      seq_q   <= seq_d;
    end
  end

`ifdef C2H_ADAPTER_STATS_EN
  logic [31:0] stat_pkts_q;
  logic [47:0] stat_bytes_q;
  logic [15:0] stat_trunc_q;

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      stat_pkts_q  <= 32'd0;
      stat_bytes_q <= 48'd0;
      stat_trunc_q <= 16'd0;
    end else if (cmpt_hs_s) begin
      stat_pkts_q  <= stat_pkts_q + 32'd1;
      stat_bytes_q <= stat_bytes_q + {32'd0, len_q};
      stat_trunc_q <= stat_trunc_q + {15'd0, trunc_q};
    end
  end

  assign stat_pkts  = stat_pkts_q;
  assign stat_bytes = stat_bytes_q;
  assign stat_trunc = stat_trunc_q;
`else
  logic unused_cmpt_hs_s;
  assign unused_cmpt_hs_s = cmpt_hs_s;
`endif

endmodule

// File: tb/tb_c2h_pkt_adapter.sv
// Directed self-checking bench for c2h_pkt_adapter (default build, 512-bit beats).
module tb_c2h_pkt_adapter;

  logic          axi_aclk = 1'b0;
  logic          axi_areset;
  logic          rx_valid;
  logic [511:0]  rx_data;
  logic [63:0]   rx_ben;
  logic          rx_last;
  logic          rx_ready;
  logic [10:0]   c2h_qid;
  logic          m_c2h_tvalid;
  logic          m_c2h_tready;
  logic [511:0]  m_c2h_tdata;
  logic          m_c2h_tlast;
  logic [15:0]   m_c2h_len;
  logic [5:0]    m_c2h_mty;
  logic [10:0]   m_c2h_qid;
  logic          cmpt_valid;
  logic          cmpt_ready;
  logic [63:0]   cmpt_data;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_seq = 0;

  always #5 axi_aclk = ~axi_aclk;

  c2h_pkt_adapter dut (
    .axi_aclk     (axi_aclk),
    .axi_areset   (axi_areset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ben       (rx_ben),
    .rx_last      (rx_last),
    .rx_ready     (rx_ready),
    .c2h_qid      (c2h_qid),
    .m_c2h_tvalid (m_c2h_tvalid),
    .m_c2h_tready (m_c2h_tready),
    .m_c2h_tdata  (m_c2h_tdata),
    .m_c2h_tlast  (m_c2h_tlast),
    .m_c2h_len    (m_c2h_len),
    .m_c2h_mty    (m_c2h_mty),
    .m_c2h_qid    (m_c2h_qid),
    .cmpt_valid   (cmpt_valid),
    .cmpt_ready   (cmpt_ready),
    .cmpt_data    (cmpt_data)
  );

  typedef struct {
    int nbytes;
    int qid;
    int beats;
    int len;
    int mty;
    int trunc;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic logic [511:0] pat(input int pid, input int b);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = {pid[15:0], b[15:0]};
    return r;
  endfunction

  task automatic push_beat(input logic [511:0] d, input logic [63:0] ben, input logic last);
    int t = 0;
    rx_valid = 1'b1; rx_data = d; rx_ben = ben; rx_last = last;
    @(negedge axi_aclk);
    while (!rx_ready && t < 2000) begin @(negedge axi_aclk); t++; end
    if (!rx_ready) begin
      timeout_fail("rx_ready_wait");
      rx_valid = 1'b0;
      return;
    end
    @(posedge axi_aclk); #1;
    rx_valid = 1'b0; rx_last = 1'b0;
  endtask

  task automatic push_pkt(input int pid, input int nbytes);
    int nb;
    int rem;
    logic [63:0] ben;
    nb  = (nbytes == 0) ? 1 : (nbytes + 63) / 64;
    rem = nbytes;
    for (int b = 0; b < nb; b++) begin
      ben = 64'd0;
      for (int i = 0; i < 64; i++) if (i < rem) ben[i] = 1'b1;
      push_beat(pat(pid, b), ben, (b == nb - 1));
      rem -= 64;
    end
  endtask

  task automatic do_cmpt(input int len, input int trunc);
    int t = 0;
    logic [63:0] exp;
    @(negedge axi_aclk);
    while (!cmpt_valid && t < 1000) begin @(negedge axi_aclk); t++; end
    if (!cmpt_valid) begin
      timeout_fail("cmpt_valid_wait");
      return;
    end
    exp = {31'd0, trunc[0], exp_seq[15:0], len[15:0]};
    check($sformatf("cmpt_data seq%0d", exp_seq), cmpt_data, exp);
    cmpt_ready = 1'b1;
    @(posedge axi_aclk); #1;
    cmpt_ready = 1'b0;
    exp_seq++;
  endtask

  task automatic recv_pkt(input int pid, input int beats, input int len, input int mty,
                          input int qid, input int trunc, input bit cmpt);
    for (int k = 0; k < beats; k++) begin
      int t = 0;
      @(negedge axi_aclk);
      while (!m_c2h_tvalid && t < 1000) begin @(negedge axi_aclk); t++; end
      if (!m_c2h_tvalid) begin
        timeout_fail($sformatf("tvalid_wait p%0d b%0d", pid, k));
        return;
      end
      check($sformatf("tdata p%0d b%0d", pid, k), m_c2h_tdata, pat(pid, k));
      check($sformatf("tlast p%0d b%0d", pid, k), m_c2h_tlast, (k == beats - 1));
      check($sformatf("len p%0d b%0d", pid, k), m_c2h_len, len);
      check($sformatf("mty p%0d b%0d", pid, k), m_c2h_mty, (k == beats - 1) ? mty : 0);
      check($sformatf("qid p%0d b%0d", pid, k), m_c2h_qid, qid);
      m_c2h_tready = 1'b1;
      @(posedge axi_aclk); #1;
      m_c2h_tready = 1'b0;
    end
    if (cmpt) do_cmpt(len, trunc);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " tvalid"}, m_c2h_tvalid, 0);
    check({tag, " tlast"}, m_c2h_tlast, 0);
    check({tag, " tdata"}, m_c2h_tdata, 0);
    check({tag, " len"}, m_c2h_len, 0);
    check({tag, " mty"}, m_c2h_mty, 0);
    check({tag, " qid"}, m_c2h_qid, 0);
    check({tag, " cmpt_valid"}, cmpt_valid, 0);
    check({tag, " cmpt_data"}, cmpt_data, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hold_bad;
    logic [63:0] held;

    vt[0] = '{256,  5,     4,  256,  0, 0};
    vt[1] = '{100,  7,     2,  100, 28, 0};
    vt[2] = '{5000, 3,     64, 4096, 0, 1};
    vt[3] = '{64,   1,     1,  64,   0, 0};
    vt[4] = '{0,    2,     1,  0,    0, 0};
    vt[5] = '{1,    2047,  1,  1,   63, 0};
    vt[6] = '{4096, 9,     64, 4096, 0, 0};
    vt[7] = '{4097, 4,     64, 4096, 0, 1};

    axi_areset = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_ben = '0; rx_last = 1'b0;
    c2h_qid = '0; m_c2h_tready = 1'b0; cmpt_ready = 1'b0;
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
    check("reset rx_ready", rx_ready, 0);
    check_idle_outputs("reset");
    @(posedge axi_aclk); #1;
    axi_areset = 1'b0;
    @(negedge axi_aclk);
    check("post_reset rx_ready", rx_ready, 1);
    @(posedge axi_aclk); #1;

    // Table-driven single packets.
    for (int i = 0; i < 8; i++) begin
      c2h_qid = vt[i].qid[10:0];
      push_pkt(100 + i, vt[i].nbytes);
      @(negedge axi_aclk);
      check($sformatf("latency p%0d", 100 + i), m_c2h_tvalid, 0);
      recv_pkt(100 + i, vt[i].beats, vt[i].len, vt[i].mty, vt[i].qid, vt[i].trunc, 1'b1);
    end

    // Backpressure: 128 buffered beats fill the data FIFO.
    c2h_qid = 11'h0AA;
    for (int p = 0; p < 4; p++) push_pkt(20 + p, 2048);
    @(negedge axi_aclk);
    check("rx_ready_at_128", rx_ready, 0);
    hold_bad = 0;
    repeat (70) begin
      @(negedge axi_aclk);
      if (rx_ready || !m_c2h_tvalid) hold_bad++;
    end
    check("full_hold", hold_bad, 0);
    fork
      push_pkt(24, 2048);
      for (int p = 0; p < 5; p++) recv_pkt(20 + p, 32, 2048, 0, 11'h0AA, 0, 1'b1);
    join

    // Completion backpressure holds off the next packet.
    c2h_qid = 11'h123;
    push_pkt(40, 64);
    push_pkt(41, 64);
    recv_pkt(40, 1, 64, 0, 11'h123, 0, 1'b0);
    @(negedge axi_aclk);
    held = cmpt_data;
    check("cmpt_held_data", held, {31'd0, 1'b0, exp_seq[15:0], 16'd64});
    hold_bad = 0;
    repeat (20) begin
      @(negedge axi_aclk);
      if (!cmpt_valid || m_c2h_tvalid || cmpt_data !== held) hold_bad++;
    end
    check("cmpt_stall_hold", hold_bad, 0);
    do_cmpt(64, 0);
    recv_pkt(41, 1, 64, 0, 11'h123, 0, 1'b1);

    // Reset while one packet is buffered and another is half received.
    c2h_qid = 11'h055;
    push_pkt(50, 128);
    push_beat(pat(51, 0), {64{1'b1}}, 1'b0);
    push_beat(pat(51, 1), {64{1'b1}}, 1'b0);
    @(negedge axi_aclk);
    check("pre_reset tvalid", m_c2h_tvalid, 1);
    @(posedge axi_aclk); #1;
    axi_areset = 1'b1;
    @(negedge axi_aclk);
    check("in_reset rx_ready", rx_ready, 0);
    @(posedge axi_aclk); #1;
    axi_areset = 1'b0;
    exp_seq = 0;
    @(negedge axi_aclk);
    check_idle_outputs("mid_reset");
    check("mid_reset rx_ready", rx_ready, 1);
    @(posedge axi_aclk); #1;
    push_pkt(52, 64);
    recv_pkt(52, 1, 64, 0, 11'h055, 0, 1'b1);
    @(negedge axi_aclk);
    check("no_stale_pkt", m_c2h_tvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
